// File: rtl/sc_alien_hit_detector.sv
// Collision stage for the 2x6 alien formation: tracks the alive mask and emits one
// active-low count pulse plus a one-cycle bullet-retire pulse per kill.
module sc_alien_hit_detector #(
    parameter int unsigned ALIEN_ROWS        = 2,
    parameter int unsigned ALIEN_COLS        = 6,
    parameter int unsigned POS_WIDTH         = 3,
    parameter int unsigned KILL_PULSE_CYCLES = 2
) (
    input  logic                             SC_HITDET_CLOCK_50,
    input  logic                             SC_HITDET_RESET_InLow,
    input  logic                             SC_HITDET_load_InLow,
    input  logic                             SC_HITDET_bulletValid_InLow,
    input  logic [POS_WIDTH-1:0]             SC_HITDET_bulletRow_InBus,
    input  logic [POS_WIDTH-1:0]             SC_HITDET_bulletCol_InBus,
    input  logic [POS_WIDTH-1:0]             SC_HITDET_gridRow_InBus,
    input  logic [POS_WIDTH-1:0]             SC_HITDET_gridCol_InBus,
    output logic                             SC_HITDET_count_OutLow,
    output logic                             SC_HITDET_bulletKill_OutLow,
    output logic [ALIEN_ROWS*ALIEN_COLS-1:0] SC_HITDET_aliveMask_OutBus,
    output logic [3:0]                       SC_HITDET_hitIndex_OutBus
);

    localparam int unsigned N_ALIENS = ALIEN_ROWS * ALIEN_COLS;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned PCNT_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                r_state,        w_next_state;
    logic [N_ALIENS-1:0]   r_alive_mask,   w_next_alive_mask;
    logic                  r_count_n,      w_next_count_n;
    logic                  r_bullet_kill_n, w_next_bullet_kill_n;
    logic [IDX_W-1:0]      r_hit_index,    w_next_hit_index;
    logic [PCNT_W-1:0]     r_pulse_cnt,    w_next_pulse_cnt;

    logic [POS_WIDTH-1:0]  w_rel_row;
    logic [POS_WIDTH-1:0]  w_rel_col;
    logic                  w_in_range;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_hit;

    // Relative position; the >= guards stop an underflowing subtraction from aliasing into range.
    always_comb begin
        w_rel_row  = SC_HITDET_bulletRow_InBus - SC_HITDET_gridRow_InBus;
        w_rel_col  = SC_HITDET_bulletCol_InBus - SC_HITDET_gridCol_InBus;
        w_in_range = (SC_HITDET_bulletRow_InBus >= SC_HITDET_gridRow_InBus) &&
                     (w_rel_row < POS_WIDTH'(ALIEN_ROWS)) &&
                     (SC_HITDET_bulletCol_InBus >= SC_HITDET_gridCol_InBus) &&
                     (w_rel_col < POS_WIDTH'(ALIEN_COLS));
        w_idx      = IDX_W'(32'(w_rel_row) * ALIEN_COLS + 32'(w_rel_col));
        w_hit      = !SC_HITDET_bulletValid_InLow && w_in_range && r_alive_mask[w_idx];
    end

    // Next-state and registered-output logic
    always_comb begin
        w_next_state         = r_state;
        w_next_alive_mask    = r_alive_mask;
        w_next_count_n       = r_count_n;
        w_next_bullet_kill_n = 1'b1;
        w_next_hit_index     = r_hit_index;
        w_next_pulse_cnt     = r_pulse_cnt;

        case (r_state)
            IDLE: begin
                if (!SC_HITDET_load_InLow) begin
                    w_next_alive_mask = {N_ALIENS{1'b1}};
                end else if (w_hit) begin
                    w_next_alive_mask    = r_alive_mask & ~(N_ALIENS'(1) << w_idx);
                    w_next_hit_index     = w_idx;
                    w_next_count_n       = 1'b0;
                    w_next_bullet_kill_n = 1'b0;
                    w_next_pulse_cnt     = PCNT_W'(1);
                    w_next_state         = KILL;
                end
            end
            KILL: begin
                if (!SC_HITDET_load_InLow) begin
                    w_next_alive_mask = {N_ALIENS{1'b1}};
                    w_next_count_n    = 1'b1;
                    w_next_pulse_cnt  = '0;
                    w_next_state      = IDLE;
                end else if (r_pulse_cnt == PCNT_W'(KILL_PULSE_CYCLES)) begin
                    w_next_count_n   = 1'b1;
                    w_next_pulse_cnt = '0;
                    w_next_state     = HOLD;
                end else begin
                    w_next_pulse_cnt = r_pulse_cnt + PCNT_W'(1);
                end
            end
            HOLD: begin
                if (!SC_HITDET_load_InLow) begin
                    w_next_alive_mask = {N_ALIENS{1'b1}};
                    w_next_count_n    = 1'b1;
                    w_next_state      = IDLE;
                end else if (SC_HITDET_bulletValid_InLow) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_count_n   = 1'b1;
                w_next_pulse_cnt = '0;
                w_next_state     = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge SC_HITDET_CLOCK_50 or negedge SC_HITDET_RESET_InLow) begin
        if (!SC_HITDET_RESET_InLow) begin
            r_state         <= IDLE;
            r_alive_mask    <= {N_ALIENS{1'b1}};
            r_count_n       <= 1'b1;
            r_bullet_kill_n <= 1'b1;
            r_hit_index     <= '0;
            r_pulse_cnt     <= '0;
        end else begin
            r_state         <= w_next_state;
            r_alive_mask    <= w_next_alive_mask;
            r_count_n       <= w_next_count_n;
            r_bullet_kill_n <= w_next_bullet_kill_n;
            r_hit_index     <= w_next_hit_index;
            r_pulse_cnt     <= w_next_pulse_cnt;
        end
    end

    assign SC_HITDET_count_OutLow      = r_count_n;
    assign SC_HITDET_bulletKill_OutLow = r_bullet_kill_n;
    assign SC_HITDET_aliveMask_OutBus  = r_alive_mask;
    assign SC_HITDET_hitIndex_OutBus   = r_hit_index;

endmodule

// File: doc/sc_alien_hit_detector.md
Name: sc_alien_hit_detector

Overview:
- Collision and kill-event stage directly upstream of the alien kill counter.
- Compares the player bullet position against the 2x6 alien formation on the 8x8 matrix and keeps the alive mask.
- On each hit, drives an active-low count pulse of KILL_PULSE_CYCLES cycles into the counter's count_InLow input, so 12 aliens x 2 = 24 counts, which is the counter's end-of-count value.
- Also tells the bullet block to retire the bullet.

Parameters:
- ALIEN_ROWS, 2, rows in the formation.
- ALIEN_COLS, 6, columns in the formation.
- POS_WIDTH, 3, width of the matrix row/column coordinates.
- KILL_PULSE_CYCLES, 2, low cycles of the count pulse per kill; range 1..7.

Ports:
- SC_HITDET_CLOCK_50  input  1  system clock, all registers on the rising edge.
- SC_HITDET_RESET_InLow  input  1  asynchronous active-low reset.
- SC_HITDET_load_InLow  input  1  new wave; low for at least 1 cycle sets all aliens alive.
- SC_HITDET_bulletValid_InLow  input  1  low while a bullet is on the matrix.
- SC_HITDET_bulletRow_InBus  input  POS_WIDTH  bullet row.
- SC_HITDET_bulletCol_InBus  input  POS_WIDTH  bullet column.
- SC_HITDET_gridRow_InBus  input  POS_WIDTH  formation origin row (top-left alien).
- SC_HITDET_gridCol_InBus  input  POS_WIDTH  formation origin column.
- SC_HITDET_count_OutLow  output  1  kill pulse to the counter's count_InLow.
- SC_HITDET_bulletKill_OutLow  output  1  one-cycle pulse that retires the bullet.
- SC_HITDET_aliveMask_OutBus  output  ALIEN_ROWS*ALIEN_COLS  bit i = alien i alive; i = r*ALIEN_COLS + c.
- SC_HITDET_hitIndex_OutBus  output  4  index of the last killed alien.

Behaviour:
- Reset (asynchronous, low), all outputs registered:
  - aliveMask = all ones.
  - count_OutLow = 1.
  - bulletKill_OutLow = 1.
  - hitIndex = 0.
  - state = IDLE.
  - pulse counter = 0.
- Hit, combinational:
  - bulletValid_InLow = 0.
  - bulletRow >= gridRow and (bulletRow - gridRow) < ALIEN_ROWS.
  - bulletCol >= gridCol and (bulletCol - gridCol) < ALIEN_COLS.
  - aliveMask[idx] = 1, with idx = relRow*ALIEN_COLS + relCol.
  - Comparisons use POS_WIDTH bits with no wrap: a bullet above or left of the origin never hits.
- IDLE:
  - load low: aliveMask <= all ones; stay in IDLE. Load has priority over hit.
  - Otherwise, on hit at edge N:
    - aliveMask[idx] <= 0.
    - hitIndex <= idx.
    - count_OutLow <= 0.
    - bulletKill_OutLow <= 0.
    - pulse counter <= 1.
    - Go to KILL.
- KILL:
  - bulletKill_OutLow returns to 1 after exactly 1 cycle.
  - count_OutLow stays 0 for exactly KILL_PULSE_CYCLES cycles (edge N to edge N+KILL_PULSE_CYCLES), then returns to 1.
  - Then go to HOLD.
  - No new hit is evaluated in KILL.
- HOLD:
  - Wait for bulletValid_InLow = 1 (bullet released), then go to IDLE.
  - This guarantees one kill per bullet.
- load low in KILL or HOLD:
  - Abort at the next edge: count_OutLow = 1, bulletKill_OutLow = 1, aliveMask = all ones, state = IDLE.
  - The partial pulse is accepted; the counter is reset separately at wave start.
- Dead alien at the bullet position: no hit and no pulse; the bullet passes through.
- Formation origin changing during KILL/HOLD has no effect.
- All aliens dead: aliveMask = 0; no further hits are possible.
- Latency: hit to count/bulletKill low = 1 clock edge.

Test Plan:
- Reset, then release: aliveMask = 12'hFFF, count_OutLow = 1, bulletKill_OutLow = 1, hitIndex = 0.
- Grid (2,1), bullet valid at (3,4):
  - idx = 1*6 + 3 = 9; the next edge clears bit 9 (mask 12'hDFF) and sets hitIndex = 9.
  - bulletKill low for 1 cycle, count low for 2 cycles.
  - The bullet held valid for 10 more cycles produces no second pulse.
- Bullet at (1,4) with grid (2,1), above the origin: no hit, no mask change, outputs stay high.
- Kill all 12 aliens in sequence, releasing the bullet between kills:
  - 24 total count-low cycles.
  - aliveMask = 0.
  - A connected counter reaches 24 and asserts its eoc low.
- Re-fire at an already-killed alien's position: no pulse.
- load low one cycle after a hit (during KILL):
  - count_OutLow returns to 1 at the next edge.
  - aliveMask = 12'hFFF.
  - state = IDLE, and a new hit is accepted immediately.
- Asynchronous reset mid-KILL: outputs return to reset values without waiting for a clock edge.
